// File: rtl/window_feeder.sv
// window_feeder: turns a raster-order pixel stream into 3x3 windows for a
// processing element. Two line buffers hold the previous two rows; a 3x3
// register window slides one column per accepted pixel.
module window_feeder #(
    parameter int CELL_BIT = 8,
    parameter int N_CELL   = 9,
    parameter int MAX_W    = 64
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [6:0]                 img_w,
    input  logic [6:0]                 img_h,
    input  logic [CELL_BIT-1:0]        pix_in,
    input  logic                       pix_valid,
    output logic                       pix_ready,
    output logic [CELL_BIT*N_CELL-1:0] win_out,
    output logic                       en,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
    localparam logic [6:0] MAX_W7 = 7'(MAX_W);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                              state, state_nxt;
    logic [6:0]                          w_lat, h_lat, row, col;
    logic                                accept, last_pix, size_ok, win_fire;
    logic [AW-1:0]                       ca;
    logic [CELL_BIT-1:0]                 lb_a [MAX_W];   // row r-1
    logic [CELL_BIT-1:0]                 lb_b [MAX_W];   // row r-2
    logic [2:0][2:0][CELL_BIT-1:0]       win, win_nxt;   // [row][col], col 2 newest
    logic [CELL_BIT*N_CELL-1:0]          win_flat;

    assign pix_ready = (state == RUN);
    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign accept    = pix_valid && pix_ready;
    assign ca        = col[AW-1:0];
    assign size_ok   = (img_w >= 7'd3) && (img_w <= MAX_W7) &&
                       (img_h >= 7'd3) && (img_h <= 7'd64);
    assign last_pix  = (row == h_lat - 7'd1) && (col == w_lat - 7'd1);
    // A window only exists once three full rows and three columns of the
    // current row are in; this also keeps windows from spanning a wrap.
    assign win_fire  = accept && (row >= 7'd2) && (col >= 7'd2);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && size_ok) state_nxt = RUN;
            RUN:     if (accept && last_pix) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Frame geometry latch and raster position counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_lat <= '0;
            h_lat <= '0;
            row   <= '0;
            col   <= '0;
        end else if (state == IDLE && start && size_ok) begin
            w_lat <= img_w;
            h_lat <= img_h;
            row   <= '0;
            col   <= '0;
        end else if (accept) begin
            if (col == w_lat - 7'd1) begin
                col <= '0;
                row <= row + 7'd1;
            end else begin
                col <= col + 7'd1;
            end
        end
    end

    // Shifted window and its row-major flattening, (r-2,c-2) in the top cell
    always_comb begin
        win_nxt = win;
        for (int i = 0; i < 3; i++) begin
            win_nxt[i][0] = win[i][1];
            win_nxt[i][1] = win[i][2];
        end
        win_nxt[0][2] = lb_b[ca];
        win_nxt[1][2] = lb_a[ca];
        win_nxt[2][2] = pix_in;
        win_flat = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
                win_flat[(N_CELL-1-(i*3+j))*CELL_BIT +: CELL_BIT] = win_nxt[i][j];
    end

    // Sliding window registers advance on every accept
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      win <= '0;
        else if (accept) win <= win_nxt;
    end

    // Output window register; holds its value between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en      <= 1'b0;
            win_out <= '0;
        end else begin
            en <= win_fire;
            if (win_fire) win_out <= win_flat;
        end
    end

    // Line buffers: contents are don't-care after reset, so no reset branch
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_b[ca] <= lb_a[ca];
            lb_a[ca] <= pix_in;
        end
    end

endmodule

// File: doc/window_feeder.md
WINDOW_FEEDER -- requirements
Module: window_feeder

Interface
REQ-001 SHALL have parameter CELL_BIT, default 8, pixel width in bits.
REQ-002 SHALL have parameter N_CELL, default 9, pixels per window (3x3, fixed).
REQ-003 SHALL have parameter MAX_W, default 64, maximum image width in pixels (line-buffer depth).
REQ-004 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port img_w  input  7  image width in pixels, sampled with start.
REQ-008 SHALL have port img_h  input  7  image height in pixels, sampled with start.
REQ-009 SHALL have port pix_in  input  CELL_BIT  raster-order pixel stream.
REQ-010 SHALL have port pix_valid  input  1  pix_in valid.
REQ-011 SHALL have port pix_ready  output  1  block accepts a pixel this cycle.
REQ-012 SHALL have port win_out  output  CELL_BIT*N_CELL  3x3 window; feeds the PE "in" port.
REQ-013 SHALL have port en  output  1  win_out valid for one cycle; feeds the PE "en" port.
REQ-014 SHALL have port busy  output  1  high in RUN.
REQ-015 SHALL have port done  output  1  one-cycle pulse at end of frame.

Function
REQ-016 SHALL implement FSM IDLE -> RUN -> DONE -> IDLE.
REQ-017 IDLE: start=1 with 3<=img_w<=MAX_W and 3<=img_h<=64 SHALL latch img_w/img_h, clear row/col counters, enter RUN; out-of-range start SHALL be ignored (stay IDLE).
REQ-018 start outside IDLE SHALL be ignored; img_w/img_h changes after latch SHALL have no effect.
REQ-019 pix_ready SHALL be 1 in RUN only; a pixel is accepted when pix_valid & pix_ready.
REQ-020 On accept, pixel SHALL be at (row r, col c); col wraps w-1 -> 0 with row+1; cycles without accept SHALL change no state.
REQ-021 SHALL keep two line buffers of MAX_W x CELL_BIT holding rows r-1, r-2, plus a 3x3 register window shifted on each accept.
REQ-022 Accept with r>=2 and c>=2 SHALL produce en=1 in the next cycle, with win_out = pixels (r-2..r, c-2..c); otherwise en=0.
REQ-023 Packing: win_out[71:64] = (r-2,c-2), row-major, win_out[7:0] = (r,c) = current pixel.
REQ-024 win_out SHALL hold its last value when en=0.
REQ-025 Windows per frame SHALL be exactly (h-2)*(w-2); no window SHALL mix pixels across a column wrap.
REQ-026 Accept of (h-1,w-1) SHALL move to DONE next cycle (pix_ready=0); DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-027 The final en and done SHALL occur in the same cycle.
REQ-028 Sustained throughput SHALL be one pixel per cycle with pix_valid held high.

Reset
REQ-029 reset=0 SHALL immediately force IDLE, counters 0, win_out=0, en=0, busy=0, done=0, pix_ready=0, regardless of clk.
REQ-030 Reset mid-frame SHALL abort the frame; no en/done SHALL follow; line-buffer contents are don't-care, and the next frame SHALL be correct.

Verification
REQ-031 4x4, pixels 0..15, pix_valid=1 -> 4 en pulses; first after pixel 10 with win_out={0,1,2,4,5,6,8,9,10}; last {5,6,7,9,10,11,13,14,15} with done.
REQ-032 3x3, pixels 1..9 -> one en, win_out={1..9}; done same cycle; busy low the cycle after.
REQ-033 4x4 with pix_valid toggling every other cycle -> same 4 windows/values as REQ-031, each en 1 cycle after its accept.
REQ-034 64x3 frame -> 62 en pulses, none at col 0/1; start asserted mid-frame ignored; img_w=2 or 65 start -> stays IDLE.
REQ-035 reset pulsed after 7 pixels of 4x4 frame -> all outputs 0 at once, no en/done; new 4x4 frame then matches REQ-031.
